conv_addr_gen: RTL and testbench

- Parametrised successor to the tile address FSM.
- Walks every filter window of a tile held in linear on-chip memory and emits one read address per filter tap.
- Supports any filter size, any stride and any tile geometry up to the parameter limits, with valid/ready back-pressure.
- Sits between the layer controller (config + start) and the tile buffer read port; window markers drive the compute unit.

---
 rtl/conv_addr_gen.sv | 219 +++++++++++++++++++++
 tb/tb_conv_addr_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: sweeps every k x k window of a linear tile at stride s, one tap address per accepted beat.
// Optional MULTI_CH_EN repeats the sweep per channel plane (adds cfg_chans input, ch_out output).
module conv_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int DIM_W  = 6,
  parameter int FILT_W = 3
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]  cfg_tile_w,
  input  logic [DIM_W-1:0]  cfg_tile_h,
  input  logic [FILT_W-1:0] cfg_filt,
  input  logic [FILT_W-1:0] cfg_stride,
`ifdef MULTI_CH_EN
  input  logic [FILT_W-1:0] cfg_chans,
  output logic [FILT_W-1:0] ch_out,
`endif
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              win_first,
  output logic              win_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  // XW is wide enough that no step can wrap past the overflow bits
  localparam int XW = ADDR_W + 2*DIM_W;
  localparam int PW = DIM_W + 2;

  typedef enum logic [2:0] {IDLE, CHECK, RUN, DONE, ERR} state_t;
  state_t state;

  logic [ADDR_W-1:0] base_r, win_start, row_org;
  logic [DIM_W-1:0]  tw, th;
  logic [FILT_W-1:0] k, s, fx, fy, km1, fx_n, fy_n;
  logic [PW-1:0]     ox_pos, oy_pos, ox_n, oy_n;
  logic [XW-1:0]     row_step, row_step_c, nxt;
  logic              tap_end, row_end, ox_more, oy_more;
  logic              last_beat, ovf, cfg_bad, new_win, new_row;
`ifdef MULTI_CH_EN
  logic [FILT_W-1:0] chans, ch_n;
  logic [ADDR_W-1:0] plane_base;
  logic [XW-1:0]     plane_size, plane_size_c;
  logic              new_plane;
`endif

  always_comb begin
    km1 = k - FILT_W'(1);
    // s*tile_w by shift-add over the few stride bits
    row_step_c = '0;
    for (int i = 0; i < FILT_W; i++)
      if (s[i]) row_step_c = row_step_c + (XW'(tw) << i);
    tap_end = (fx == km1);
    row_end = (fy == km1);
    ox_more = (ox_pos + PW'(s) + PW'(k)) <= PW'(tw);
    oy_more = (oy_pos + PW'(s) + PW'(k)) <= PW'(th);
    cfg_bad = (k == '0) || (s == '0) || (PW'(k) > PW'(tw)) || (PW'(k) > PW'(th));
`ifdef MULTI_CH_EN
    cfg_bad = cfg_bad || (chans == '0);
    plane_size_c = '0;
    for (int i = 0; i < DIM_W; i++)
      if (th[i]) plane_size_c = plane_size_c + (XW'(tw) << i);
    ch_n      = ch_out;
    new_plane = 1'b0;
`endif
    nxt       = '0;
    fx_n      = '0;
    fy_n      = '0;
    ox_n      = ox_pos;
    oy_n      = oy_pos;
    new_win   = 1'b0;
    new_row   = 1'b0;
    last_beat = 1'b0;
    if (!tap_end) begin
      nxt  = XW'(addr_out) + XW'(1);
      fx_n = fx + FILT_W'(1);
      fy_n = fy;
    end else if (!row_end) begin
      nxt  = XW'(addr_out) + XW'(tw) - XW'(km1);
      fy_n = fy + FILT_W'(1);
    end else if (ox_more) begin
      nxt     = XW'(win_start) + XW'(s);
      ox_n    = ox_pos + PW'(s);
      new_win = 1'b1;
    end else if (oy_more) begin
      nxt     = XW'(row_org) + row_step;
      ox_n    = '0;
      oy_n    = oy_pos + PW'(s);
      new_win = 1'b1;
      new_row = 1'b1;
`ifdef MULTI_CH_EN
    end else if (ch_out != chans - FILT_W'(1)) begin
      nxt       = XW'(plane_base) + plane_size;
      ox_n      = '0;
      oy_n      = '0;
      ch_n      = ch_out + FILT_W'(1);
      new_win   = 1'b1;
      new_row   = 1'b1;
      new_plane = 1'b1;
`endif
    end else begin
      last_beat = 1'b1;
    end
    ovf = |nxt[XW-1:ADDR_W];
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      win_first  <= 1'b0;
      win_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      base_r     <= '0;
      tw         <= '0;
      th         <= '0;
      k          <= '0;
      s          <= '0;
      fx         <= '0;
      fy         <= '0;
      ox_pos     <= '0;
      oy_pos     <= '0;
      win_start  <= '0;
      row_org    <= '0;
      row_step   <= '0;
`ifdef MULTI_CH_EN
      chans      <= '0;
      ch_out     <= '0;
      plane_base <= '0;
      plane_size <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_r <= cfg_base;
            tw     <= cfg_tile_w;
            th     <= cfg_tile_h;
            k      <= cfg_filt;
            s      <= cfg_stride;
`ifdef MULTI_CH_EN
            chans  <= cfg_chans;
`endif
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (cfg_bad) begin
            state <= ERR;
          end else begin
            addr_out  <= base_r;
            win_start <= base_r;
            row_org   <= base_r;
            row_step  <= row_step_c;
            fx        <= '0;
            fy        <= '0;
            ox_pos    <= '0;
            oy_pos    <= '0;
`ifdef MULTI_CH_EN
            ch_out     <= '0;
            plane_base <= base_r;
            plane_size <= plane_size_c;
`endif
            state     <= RUN;
          end
        end
        RUN: begin
          // first RUN cycle presents the preloaded base address
          if (!addr_valid) begin
            addr_valid <= 1'b1;
            win_first  <= 1'b1;
            win_last   <= (km1 == '0);
          end else if (addr_ready) begin
            if (last_beat || ovf) begin
              addr_valid <= 1'b0;
              win_first  <= 1'b0;
              win_last   <= 1'b0;
              state      <= last_beat ? DONE : ERR;
            end else begin
              addr_out  <= nxt[ADDR_W-1:0];
              fx        <= fx_n;
              fy        <= fy_n;
              ox_pos    <= ox_n;
              oy_pos    <= oy_n;
              win_first <= (fx_n == '0) && (fy_n == '0);
              win_last  <= (fx_n == km1) && (fy_n == km1);
              if (new_win) win_start <= nxt[ADDR_W-1:0];
              if (new_row) row_org   <= nxt[ADDR_W-1:0];
`ifdef MULTI_CH_EN
              ch_out <= ch_n;
              if (new_plane) plane_base <= nxt[ADDR_W-1:0];
`endif
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_addr_gen.sv
// Bench for conv_addr_gen: reference sweep built from the address formula, checked beat by beat.
`timescale 1ns/1ps
module tb_conv_addr_gen;
  localparam int ADDR_W = 10;
  localparam int DIM_W  = 6;
  localparam int FILT_W = 3;

  logic              clk = 1'b0;
  logic              res = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [DIM_W-1:0]  cfg_tile_w = '0;
  logic [DIM_W-1:0]  cfg_tile_h = '0;
  logic [FILT_W-1:0] cfg_filt = '0;
  logic [FILT_W-1:0] cfg_stride = '0;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              addr_ready = 1'b0;
  logic              win_first, win_last, busy, done, err;
`ifdef MULTI_CH_EN
  logic [FILT_W-1:0] cfg_chans = FILT_W'(1);
  logic [FILT_W-1:0] ch_out;
`endif

  conv_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .FILT_W(FILT_W)) dut (
    .clk(clk), .res(res), .start(start),
    .cfg_base(cfg_base), .cfg_tile_w(cfg_tile_w), .cfg_tile_h(cfg_tile_h),
    .cfg_filt(cfg_filt), .cfg_stride(cfg_stride),
`ifdef MULTI_CH_EN
    .cfg_chans(cfg_chans), .ch_out(ch_out),
`endif
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .win_first(win_first), .win_last(win_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_addr[$];
  bit exp_first[$];
  bit exp_last[$];
  bit exp_err;
  int w0[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int beats, firsts, lasts;

  function automatic void chk(string name, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endfunction

  // Reference sweep: direct formula over window/tap indices, truncated at the first unrepresentable address
  function automatic void build(int b, int tw, int th, int k, int s);
    exp_addr.delete();
    exp_first.delete();
    exp_last.delete();
    exp_err = (k == 0) || (s == 0) || (k > tw) || (k > th);
    if (exp_err) return;
    for (int oy = 0; oy * s + k <= th; oy++)
      for (int ox = 0; ox * s + k <= tw; ox++)
        for (int fy = 0; fy < k; fy++)
          for (int fx = 0; fx < k; fx++) begin
            int a;
            a = b + (oy * s + fy) * tw + ox * s + fx;
            if (a >= (1 << ADDR_W)) begin
              exp_err = 1'b1;
              return;
            end
            exp_addr.push_back(a);
            exp_first.push_back(fx == 0 && fy == 0);
            exp_last.push_back(fx == k - 1 && fy == k - 1);
          end
  endfunction

  task automatic run_pass(input string tag, input int b, input int tw, input int th,
                          input int k, input int s, input bit rnd,
                          output int nb, output int nf, output int nl);
    int cyc, first_valid, last_acc, err_cyc, done_cyc, done_cnt, end_cyc;
    bit stall, h_first, h_last, bad_cfg;
    logic [ADDR_W-1:0] h_addr;
    nb = 0; nf = 0; nl = 0;
    first_valid = -1; last_acc = -1; err_cyc = -1; done_cyc = -1; done_cnt = 0; end_cyc = -1;
    stall = 1'b0; h_first = 1'b0; h_last = 1'b0; h_addr = '0;
    bad_cfg = (k == 0) || (s == 0) || (k > tw) || (k > th);
    build(b, tw, th, k, s);
    @(negedge clk);
    cfg_base   = ADDR_W'(b);
    cfg_tile_w = DIM_W'(tw);
    cfg_tile_h = DIM_W'(th);
    cfg_filt   = FILT_W'(k);
    cfg_stride = FILT_W'(s);
    start      = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_err_cleared"}, err, 0);
    while (cyc < 3000 && !(end_cyc >= 0 && cyc > end_cyc + 3)) begin
      if (addr_valid && first_valid < 0) first_valid = cyc;
      if (err && err_cyc < 0) err_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if ((done || err) && end_cyc < 0) end_cyc = cyc;
      if (stall) begin
        chk({tag, "_stall_valid"}, addr_valid, 1);
        chk({tag, "_stall_addr"}, addr_out, h_addr);
        chk({tag, "_stall_first"}, win_first, h_first);
        chk({tag, "_stall_last"}, win_last, h_last);
      end
      if (last_acc >= 0 && cyc == last_acc + 1 && exp_addr.size() == 0)
        chk({tag, "_valid_drop"}, addr_valid, 0);
      if (addr_valid && addr_ready) begin
        if (exp_addr.size() == 0) begin
          chk({tag, "_extra_beat_addr"}, addr_out, -1);
        end else begin
          chk({tag, "_addr"}, addr_out, exp_addr.pop_front());
          chk({tag, "_first"}, win_first, exp_first.pop_front());
          chk({tag, "_last"}, win_last, exp_last.pop_front());
        end
        nb++;
        nf += int'(win_first);
        nl += int'(win_last);
        last_acc = cyc;
      end
      stall   = addr_valid && !addr_ready;
      h_addr  = addr_out;
      h_first = win_first;
      h_last  = win_last;
      @(negedge clk);
      cyc++;
      // a start during the pass must be ignored, new cfg included
      start = (!bad_cfg && cyc == 10);
      if (cyc == 10) cfg_base = ADDR_W'(b + 333);
      addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    addr_ready = 1'b1;
    chk({tag, "_terminated"}, (end_cyc >= 0), 1);
    chk({tag, "_beats_left"}, exp_addr.size(), 0);
    chk({tag, "_busy_end"}, busy, 0);
    if (bad_cfg) begin
      chk({tag, "_err_latency"}, err_cyc, 3);
      chk({tag, "_never_valid"}, first_valid, -1);
      chk({tag, "_no_done"}, done_cnt, 0);
    end else begin
      chk({tag, "_valid_latency"}, first_valid, 3);
      if (exp_err) begin
        chk({tag, "_ovf_err_cyc"}, err_cyc, last_acc + 2);
        chk({tag, "_no_done"}, done_cnt, 0);
      end else begin
        chk({tag, "_done_cyc"}, done_cyc, last_acc + 2);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_no_err"}, err_cyc, -1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr_out"}, addr_out, 0);
    chk({tag, "_addr_valid"}, addr_valid, 0);
    chk({tag, "_win_first"}, win_first, 0);
    chk({tag, "_win_last"}, win_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #3 res = 1'b1;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;

    // pin the reference model with hand-derived values
    build(0, 5, 5, 3, 1);
    chk("model_a_len", exp_addr.size(), 81);
    for (int i = 0; i < 9; i++) chk("model_a_win0", exp_addr[i], w0[i]);
    chk("model_a_win2", exp_addr[9], 1);
    chk("model_a_win4", exp_addr[27], 5);
    build(100, 5, 5, 3, 2);
    chk("model_b_len", exp_addr.size(), 36);
    chk("model_b_w1", exp_addr[0], 100);
    chk("model_b_w2", exp_addr[9], 102);
    chk("model_b_w3", exp_addr[18], 110);
    chk("model_b_w4", exp_addr[27], 112);
    chk("model_b_end", exp_addr[35], 124);
    build(1015, 4, 4, 2, 1);
    chk("model_ovf_err", exp_err, 1);
    chk("model_ovf_len", exp_addr.size(), 15);
    chk("model_ovf_lastaddr", exp_addr[14], 1023);

    run_pass("A", 0, 5, 5, 3, 1, 1'b0, beats, firsts, lasts);
    chk("A_beat_count", beats, 81);
    chk("A_first_pulses", firsts, 9);
    chk("A_last_pulses", lasts, 9);

    run_pass("B", 100, 5, 5, 3, 2, 1'b0, beats, firsts, lasts);
    chk("B_beat_count", beats, 36);

    run_pass("C", 0, 5, 5, 3, 1, 1'b1, beats, firsts, lasts);
    chk("C_beat_count", beats, 81);
    chk("C_first_pulses", firsts, 9);

    run_pass("K0", 0, 5, 5, 0, 1, 1'b0, beats, firsts, lasts);
    run_pass("K6", 0, 5, 5, 6, 1, 1'b0, beats, firsts, lasts);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);

    run_pass("OVF", 1015, 4, 4, 2, 1, 1'b0, beats, firsts, lasts);
    chk("OVF_beat_count", beats, 15);

    // asynchronous reset in the middle of a running pass
    @(negedge clk);
    cfg_base = 0; cfg_tile_w = 5; cfg_tile_h = 5; cfg_filt = 3; cfg_stride = 1;
    start = 1'b1; addr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrun_busy_before", busy, 1);
    #2 res = 1'b1;
    #1 chk_all_zero("midrun_reset");
    @(negedge clk);
    res = 1'b0;
    run_pass("R", 0, 5, 5, 3, 1, 1'b0, beats, firsts, lasts);
    chk("R_beat_count", beats, 81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
